// File: rtl/lap_pkg.sv
// Shared definitions for the lap store: read FSM states and default geometry.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Contents:
//   LAP_RAM_WIDTH     default width of one stored time value
//   LAP_RAM_ADDR_BITS default BRAM address width (DEPTH = 2**bits)
//   lap_state_e       read FSM state encoding
package lap_pkg;

  localparam int LAP_RAM_WIDTH     = 16;
  localparam int LAP_RAM_ADDR_BITS = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } lap_state_e;

endpackage

// File: rtl/lap_ptr_ring.sv
// Circular-store bookkeeping: head/wr_ptr/count plus full/empty and clear.
// Latency: write strobe/drop are combinational; pointers and count update next edge.
// Backpressure: none; a push while full either overwrites the oldest slot or is dropped.
//
// Optional feature macro: LAP_OVERWRITE_EN (push when full overwrites the oldest lap).
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clear           synchronous clear of pointers and count (wins over i_push)
//   i_push            append request (one-cycle strobe)
//   o_head, o_wr_ptr  oldest slot / next slot to write
//   o_count           stored entries, 0..DEPTH
//   o_full, o_empty   count == DEPTH / count == 0
//   o_wr_en           a write to slot o_wr_ptr happens this cycle
//   o_drop            the push this cycle is discarded
module lap_ptr_ring
  import lap_pkg::*;
#(
  parameter int ADDR_BITS = LAP_RAM_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_push,
  output logic [ADDR_BITS-1:0] o_head,
  output logic [ADDR_BITS-1:0] o_wr_ptr,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_wr_en,
  output logic                 o_drop
);

  localparam logic [ADDR_BITS:0] DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};

  logic [ADDR_BITS-1:0] r_head;
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_accept;
  logic w_overwrite;
  logic w_drop;
  logic w_wr_en;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~i_clear;
  assign w_accept  = w_push_ok & ~w_full;

`ifdef LAP_OVERWRITE_EN
  // Full store: the slot at wr_ptr is the oldest lap, so writing it and
  // advancing both pointers keeps the ring at DEPTH entries.
  assign w_overwrite = w_push_ok & w_full;
  assign w_drop      = 1'b0;
`else
  assign w_overwrite = 1'b0;
  assign w_drop      = w_push_ok & w_full;
`endif

  assign w_wr_en = w_accept | w_overwrite;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head   <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_head   <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en)     r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (w_accept)    r_count  <= r_count + (ADDR_BITS+1)'(1);
      if (w_overwrite) r_head   <= r_head + ADDR_BITS'(1);
    end
  end

  assign o_head   = r_head;
  assign o_wr_ptr = r_wr_ptr;
  assign o_count  = r_count;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_wr_en  = w_wr_en;
  assign o_drop   = w_drop;

endmodule

// File: rtl/lap_store_ctrl.sv
// Lap-time store controller: appends laps to a circular BRAM store, replays them oldest first.
// Latency: write in the lap_pulse cycle; fetch lap_valid in the cycle after edge N+3 (req at edge N).
// Backpressure: none; next_req is ignored while a fetch is in flight or the store is empty.
//
// Optional feature macro: LAP_OVERWRITE_EN (lap when full overwrites the oldest lap
// instead of being dropped).
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_clear             synchronous clear of bookkeeping (BRAM contents untouched)
//   i_lap_pulse         store i_time_in as a new lap
//   i_time_in           current chronometer value
//   i_next_req          fetch the next lap for display
//   o_wr_addr/o_wr_data/o_write_enable   BRAM write port
//   o_rd_addr, i_rd_data                 BRAM read port (data one cycle after address)
//   o_lap_data, o_lap_valid, o_lap_index fetched lap, update strobe, logical index
//   o_lap_count, o_empty, o_full         store occupancy
//   o_lap_dropped                        lap discarded this cycle
module lap_store_ctrl
  import lap_pkg::*;
#(
  parameter int RAM_WIDTH     = LAP_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = LAP_RAM_ADDR_BITS
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_lap_pulse,
  input  logic [RAM_WIDTH-1:0]     i_time_in,
  input  logic                     i_next_req,
  output logic [RAM_ADDR_BITS-1:0] o_wr_addr,
  output logic [RAM_WIDTH-1:0]     o_wr_data,
  output logic                     o_write_enable,
  output logic [RAM_ADDR_BITS-1:0] o_rd_addr,
  input  logic [RAM_WIDTH-1:0]     i_rd_data,
  output logic [RAM_WIDTH-1:0]     o_lap_data,
  output logic                     o_lap_valid,
  output logic [RAM_ADDR_BITS-1:0] o_lap_index,
  output logic [RAM_ADDR_BITS:0]   o_lap_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_lap_dropped
);

  logic [RAM_ADDR_BITS-1:0] w_head;
  logic [RAM_ADDR_BITS-1:0] w_wr_ptr;
  logic [RAM_ADDR_BITS:0]   w_count;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_wr_en;
  logic                     w_drop;

  lap_ptr_ring #(
    .ADDR_BITS (RAM_ADDR_BITS)
  ) u_ring (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (i_clear),
    .i_push   (i_lap_pulse),
    .o_head   (w_head),
    .o_wr_ptr (w_wr_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_wr_en  (w_wr_en),
    .o_drop   (w_drop)
  );

  // Write port is purely combinational; data is zeroed when no write so the
  // bus stays quiet between laps.
  assign o_wr_addr      = w_wr_ptr;
  assign o_wr_data      = w_wr_en ? i_time_in : '0;
  assign o_write_enable = w_wr_en;
  assign o_lap_dropped  = w_drop;
  assign o_lap_count    = w_count;
  assign o_empty        = w_empty;
  assign o_full         = w_full;

  lap_state_e               r_state;
  logic [RAM_ADDR_BITS-1:0] r_cursor;
  logic [RAM_ADDR_BITS-1:0] r_rd_addr;
  logic [RAM_WIDTH-1:0]     r_lap_data;
  logic [RAM_ADDR_BITS-1:0] r_lap_index;
  logic                     r_lap_valid;

  logic [RAM_ADDR_BITS:0]   w_cursor_nxt;
  logic                     w_cursor_wrap;

  // Cursor is a logical index from head; it wraps against the count seen in
  // PRESENT, so laps committed during the fetch extend the replay range.
  assign w_cursor_nxt  = {1'b0, r_cursor} + (RAM_ADDR_BITS+1)'(1);
  assign w_cursor_wrap = (w_cursor_nxt >= w_count);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cursor    <= '0;
      r_rd_addr   <= '0;
      r_lap_data  <= '0;
      r_lap_index <= '0;
      r_lap_valid <= 1'b0;
    end else begin
      r_lap_valid <= 1'b0;
      if (i_clear) begin
        r_state  <= IDLE;
        r_cursor <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_next_req && !w_empty) r_state <= ISSUE;
          end
          ISSUE: begin
            r_rd_addr <= w_head + r_cursor;
            r_state   <= WAIT;
          end
          WAIT: begin
            r_state <= PRESENT;
          end
          PRESENT: begin
            r_lap_data  <= i_rd_data;
            r_lap_index <= r_cursor;
            r_lap_valid <= 1'b1;
            r_cursor    <= w_cursor_wrap ? '0 : w_cursor_nxt[RAM_ADDR_BITS-1:0];
            r_state     <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_rd_addr   = r_rd_addr;
  assign o_lap_data  = r_lap_data;
  assign o_lap_valid = r_lap_valid;
  assign o_lap_index = r_lap_index;

endmodule

// File: tb/tb_lap_store_ctrl.sv
// Self-checking bench for lap_store_ctrl with a 4-entry read-first BRAM model attached.
// Directed table plus randomized laps/fetches/clears checked against a queue model.
// Expectations follow LAP_OVERWRITE_EN when that macro is defined.
module tb_lap_store_ctrl;

  localparam int W     = 16;
  localparam int AB    = 2;
  localparam int DEPTH = 4;
`ifdef LAP_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clear, lap_pulse, next_req;
  logic [W-1:0]  time_in;
  logic [AB-1:0] wr_addr, rd_addr, lap_index;
  logic [W-1:0]  wr_data, rd_data, lap_data;
  logic          write_enable, lap_valid, empty, full, lap_dropped;
  logic [AB:0]   lap_count;

  always #5 clk = ~clk;

  lap_store_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_lap_pulse(lap_pulse),
    .i_time_in(time_in), .i_next_req(next_req), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_write_enable(write_enable), .o_rd_addr(rd_addr),
    .i_rd_data(rd_data), .o_lap_data(lap_data), .o_lap_valid(lap_valid),
    .o_lap_index(lap_index), .o_lap_count(lap_count), .o_empty(empty),
    .o_full(full), .o_lap_dropped(lap_dropped)
  );

  // Read-first BRAM: registered read returns the old word on a same-address write.
  logic [W-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rd_data = '0;
  end
  always @(posedge clk) begin
    if (write_enable) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_we"}, 32'(write_enable), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_lap_data"}, 32'(lap_data), 0);
    chk({tag, "_lap_valid"}, 32'(lap_valid), 0);
    chk({tag, "_lap_index"}, 32'(lap_index), 0);
    chk({tag, "_lap_count"}, 32'(lap_count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_dropped"}, 32'(lap_dropped), 0);
  endtask

  task automatic do_lap(input logic [W-1:0] v, output logic we, output logic drop);
    lap_pulse = 1'b1;
    time_in   = v;
    #1;
    we   = write_enable;
    drop = lap_dropped;
    tick();
    lap_pulse = 1'b0;
    time_in   = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Request (optionally with a lap in the same cycle); lat = edges after the
  // request edge until lap_valid is seen, -1 if it never arrives.
  task automatic do_fetch(input bit with_lap, input logic [W-1:0] v,
                          output logic [W-1:0] d, output int idx, output int lat);
    next_req  = 1'b1;
    lap_pulse = with_lap;
    time_in   = v;
    tick();
    next_req  = 1'b0;
    lap_pulse = 1'b0;
    time_in   = '0;
    lat = -1; d = '0; idx = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (lap_valid) begin
        lat = k;
        d   = lap_data;
        idx = int'(lap_index);
        break;
      end
    end
  endtask

  // Reference model: the store as a queue of laps, oldest first.
  logic [W-1:0] mq[$];
  int           mcur;

  function automatic void m_clear();
    mq.delete();
    mcur = 0;
  endfunction

  function automatic void m_lap(input logic [W-1:0] v);
    if (mq.size() < DEPTH) begin
      mq.push_back(v);
    end else if (OVW) begin
      void'(mq.pop_front());
      mq.push_back(v);
    end
  endfunction

  function automatic void m_fetch(output logic [W-1:0] d, output int i);
    d = mq[mcur];
    i = mcur;
    mcur = (mcur + 1 >= mq.size()) ? 0 : mcur + 1;
  endfunction

  typedef struct {
    bit           is_lap;
    logic [W-1:0] din;
    logic [W-1:0] exp_data;
    int           exp_idx;
    int           exp_count;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W-1:0] d, v, ed, keep;
    logic we, drop;
    int idx, lat, ei, r, nvalid;
    logic [4:0] we_mask, drop_mask;
    bit was_empty, wl;

    vecs[0] = '{1'b1, 16'h0011, 16'h0000, 0, 1};
    vecs[1] = '{1'b1, 16'h0022, 16'h0000, 0, 2};
    vecs[2] = '{1'b1, 16'h0033, 16'h0000, 0, 3};
    vecs[3] = '{1'b0, 16'h0000, 16'h0011, 0, 3};
    vecs[4] = '{1'b0, 16'h0000, 16'h0022, 1, 3};
    vecs[5] = '{1'b0, 16'h0000, 16'h0033, 2, 3};
    vecs[6] = '{1'b0, 16'h0000, 16'h0011, 0, 3};

    rst = 1'b0; clear = 1'b0; lap_pulse = 1'b0; next_req = 1'b0; time_in = '0;
    #2 rst = 1'b1;
    #2 chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    tick();

    // Request on an empty store is ignored.
    do_fetch(1'b0, '0, d, idx, lat);
    chk("empty_req_no_valid", 32'(lat), 32'(-1));
    chk_reset_outputs("idle_after_req");

    // Directed table: three laps, then four fetches wrapping to the oldest.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_lap) begin
        do_lap(vecs[i].din, we, drop);
        chk($sformatf("tbl%0d_we", i), 32'(we), 1);
        chk($sformatf("tbl%0d_drop", i), 32'(drop), 0);
      end else begin
        do_fetch(1'b0, '0, d, idx, lat);
        chk($sformatf("tbl%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
        chk($sformatf("tbl%0d_idx", i), 32'(idx), 32'(vecs[i].exp_idx));
        chk($sformatf("tbl%0d_latency", i), 32'(lat), 3);
      end
      chk($sformatf("tbl%0d_count", i), 32'(lap_count), 32'(vecs[i].exp_count));
    end
    tick();
    chk("valid_one_cycle", 32'(lap_valid), 0);

    // Five laps into a four-deep store.
    do_clear();
    we_mask = '0; drop_mask = '0;
    for (int i = 0; i < 5; i++) begin
      do_lap(16'h000A + 16'(i), we, drop);
      we_mask[i] = we;
      drop_mask[i] = drop;
    end
    chk("ovf_full", 32'(full), 1);
    chk("ovf_count", 32'(lap_count), 4);
    chk("ovf_we_mask", 32'(we_mask), OVW ? 32'h1F : 32'h0F);
    chk("ovf_drop_mask", 32'(drop_mask), OVW ? 32'h00 : 32'h10);
    for (int i = 0; i < 4; i++) begin
      do_fetch(1'b0, '0, d, idx, lat);
      chk($sformatf("ovf_fetch%0d", i), 32'(d), (OVW ? 32'h0B : 32'h0A) + 32'(i));
      chk($sformatf("ovf_idx%0d", i), 32'(idx), 32'(i));
    end

    // clear beats a same-cycle lap; display registers hold.
    do_clear();
    do_lap(16'h0055, we, drop);
    do_lap(16'h0066, we, drop);
    do_fetch(1'b0, '0, d, idx, lat);
    chk("clr_pre_fetch", 32'(d), 32'h55);
    clear = 1'b1; lap_pulse = 1'b1; time_in = 16'h0077;
    #1 chk("clr_lap_we", 32'(write_enable), 0);
    tick();
    clear = 1'b0; lap_pulse = 1'b0; time_in = '0;
    chk("clr_count", 32'(lap_count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_lap_data", 32'(lap_data), 32'h55);
    chk("clr_lap_index", 32'(lap_index), 0);
    chk("clr_bram_kept", 32'(mem[1]), 32'h66);

    // Reset while the fetch is in WAIT.
    do_lap(16'h0099, we, drop);
    do_lap(16'h00AA, we, drop);
    do_fetch(1'b0, '0, d, idx, lat);
    chk("rstw_first", 32'(d), 32'h99);
    next_req = 1'b1;
    tick();              // ISSUE
    next_req = 1'b0;
    tick();              // WAIT, rd_addr now points at slot 1
    chk("rstw_rd_addr_set", 32'(rd_addr), 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_in_wait");
    tick(); tick();
    @(negedge clk) rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (lap_valid) nvalid++;
    end
    chk("rstw_no_valid", 32'(nvalid), 0);

    // Randomized laps, fetches (some with a same-cycle lap) and clears.
    do_clear();
    m_clear();
    keep = lap_data;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_clear();
        m_clear();
        chk("rnd_clear_hold", 32'(lap_data), 32'(keep));
      end else if (r < 10) begin
        v = 16'($urandom);
        do_lap(v, we, drop);
        chk("rnd_lap_we", 32'(we), 32'((mq.size() < DEPTH) || OVW));
        chk("rnd_lap_drop", 32'(drop), 32'((mq.size() == DEPTH) && !OVW));
        m_lap(v);
      end else begin
        wl = ($urandom_range(0, 3) == 0);
        v = 16'($urandom);
        was_empty = (mq.size() == 0);
        if (wl) m_lap(v);
        do_fetch(wl, v, d, idx, lat);
        if (was_empty) begin
          chk("rnd_empty_no_valid", 32'(lat), 32'(-1));
        end else begin
          m_fetch(ed, ei);
          chk("rnd_fetch_data", 32'(d), 32'(ed));
          chk("rnd_fetch_idx", 32'(idx), 32'(ei));
          chk("rnd_fetch_lat", 32'(lat), 3);
          keep = ed;
        end
      end
      chk("rnd_count", 32'(lap_count), 32'(mq.size()));
      chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
      chk("rnd_full", 32'(full), 32'(mq.size() == DEPTH));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
